// File: rtl/penc_arb_reg.sv
// Registered active-low priority encoder/arbiter: latches falling request edges as sticky
// pending bits and offers one winner at a time over valid/ready. PENC_RR_EN selects round-robin.
module penc_arb_reg #(
  parameter  int N     = 9,
  parameter  int CNT_W = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx_n,
  output logic             any_n,
  output logic [N-1:0]     pend,
  output logic [CNT_W-1:0] ovr_cnt,
  output logic             dbg_state_o
);

  // Handshake: an offer (out_valid high, out_idx_n stable) is consumed on the rising edge
  // where out_valid && out_ready; out_ready while out_valid is low is ignored.

  typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     req_q;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     fall, clr;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_n_q, out_idx_n_d;
  logic [IDX_W-1:0] win_idx, acc_idx;
  logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic             any_n_q, any_n_d;
  logic             accept, ovr_hit;

  assign fall    = req_q & ~req_n;
  assign accept  = out_valid_q & out_ready;
  assign acc_idx = ~out_idx_n_q;

  always_comb begin
    clr = '0;
    if (accept) clr[acc_idx] = 1'b1;
  end

  // Set wins over clear: a fresh fall on the line being accepted stays pending.
  assign pend_d  = (pend_q & ~clr) | fall;
  assign ovr_hit = |(fall & pend_q & ~clr);

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_hit && (ovr_cnt_q != {CNT_W{1'b1}})) ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
  end

`ifdef PENC_RR_EN
  logic [IDX_W-1:0] last_q, last_d;
  logic             found;

  // Search downward from last-1 with wrap; k == N lands on last itself.
  always_comb begin
    win_idx = last_q;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && pend_q[(int'(last_q) + N - k) % N]) begin
        win_idx = IDX_W'((int'(last_q) + N - k) % N);
        found   = 1'b1;
      end
    end
  end

  assign last_d = accept ? acc_idx : last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= IDX_W'(N - 1);
    else     last_q <= last_d;
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_n_d = out_idx_n_q;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          out_idx_n_d = ~win_idx;
          out_valid_d = 1'b1;
          state_d     = S_OFFER;
        end
      end
      S_OFFER: begin
        if (accept) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign any_n_d = ~((|pend_d) | out_valid_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= '1;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_n_q <= '1;
      ovr_cnt_q   <= '0;
      any_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_n;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_idx_n_q <= out_idx_n_d;
      ovr_cnt_q   <= ovr_cnt_d;
      any_n_q     <= any_n_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_idx_n   = out_idx_n_q;
  assign pend        = pend_q;
  assign ovr_cnt     = ovr_cnt_q;
  assign any_n       = any_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_penc_arb_reg.sv
// Directed bench for penc_arb_reg (N=9): grants, priority, hold, overrun, reset mid-offer.
module tb_penc_arb_reg;

  localparam int N     = 9;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_n;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx_n;
  logic             any_n;
  logic [N-1:0]     pend;
  logic [CNT_W-1:0] ovr_cnt;
  logic             dbg_state_o;

  penc_arb_reg #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_n(req_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx_n(out_idx_n), .any_n(any_n), .pend(pend), .ovr_cnt(ovr_cnt),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_extra;
  logic [IDX_W-1:0] exp_q[$];
  int gcyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboard: every sampled accept is matched against the head of exp_q.
  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (out_valid && out_ready) begin
        gcyc.push_back(cyc);
        if (exp_q.size() == 0) n_extra++;
        else chk({tag, "_grant"}, 32'(out_idx_n), 32'(exp_q.pop_front()));
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; req_n = '1; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) tick();
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_idx",   32'(out_idx_n), 32'hF);
    chk("t1_any",   32'(any_n),     32'd1);
    chk("t1_pend",  32'(pend),      32'd0);
    chk("t1_ovr",   32'(ovr_cnt),   32'd0);
    chk("t1_state", 32'(dbg_state_o), 32'd0);

    // 2: held-low line 8 gives exactly one grant
    req_n[8] = 1'b0; out_ready = 1'b1;
    tick();
    chk("t2_pend_set", 32'(pend),      32'h100);
    chk("t2_valid_e1", 32'(out_valid), 32'd0);
    chk("t2_any_e1",   32'(any_n),     32'd0);
    tick();
    chk("t2_valid_e2", 32'(out_valid), 32'd1);
    chk("t2_idx",      32'(out_idx_n), 32'b0111);
    tick();
    chk("t2_valid_acc", 32'(out_valid), 32'd0);
    chk("t2_pend_clr",  32'(pend),      32'd0);
    chk("t2_any_acc",   32'(any_n),     32'd1);
    n_extra = 0;
    run_cycles(10, "t2");
    chk("t2_extra", 32'(n_extra), 32'd0);
    req_n[8] = 1'b1;
    tick(); tick();

    // 3: lines 3 and 5 together, fixed priority, two cycles apart
    n_extra = 0; gcyc.delete();
    exp_q.push_back(4'b1010); exp_q.push_back(4'b1100);
    req_n[3] = 1'b0; req_n[5] = 1'b0;
    run_cycles(10, "t3");
    chk("t3_left",  32'(exp_q.size()), 32'd0);
    chk("t3_extra", 32'(n_extra), 32'd0);
    chk("t3_count", 32'(gcyc.size()), 32'd2);
    if (gcyc.size() >= 2) chk("t3_gap", 32'(gcyc[1] - gcyc[0]), 32'd2);
    req_n = '1;
    tick(); tick();

    // 4: stalled offer holds, second fall on line 2 counts as overrun
    out_ready = 1'b0; req_n[2] = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_idx",   32'(out_idx_n), 32'b1101);
      tick();
    end
    req_n[2] = 1'b1; tick();
    req_n[2] = 1'b0; tick();
    chk("t4_ovr",       32'(ovr_cnt),   32'd1);
    chk("t4_idx_after", 32'(out_idx_n), 32'b1101);
    n_extra = 0; gcyc.delete();
    out_ready = 1'b1;
    exp_q.push_back(4'b1101);
    run_cycles(6, "t4");
    chk("t4_left",  32'(exp_q.size()), 32'd0);
    chk("t4_extra", 32'(n_extra), 32'd0);
    chk("t4_pend",  32'(pend), 32'd0);
    req_n = '1;
    tick(); tick();

`ifdef PENC_RR_EN
    // 5: round-robin among 8, 4, 0 with re-request after each grant
    begin
      logic [N-1:0] rearm;
      int g;
      int ng;
      rearm = '0; ng = 0;
      exp_q.push_back(4'b0111); exp_q.push_back(4'b1011); exp_q.push_back(4'b1111);
      exp_q.push_back(4'b0111); exp_q.push_back(4'b1011);
      req_n[8] = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
        req_n = req_n & ~rearm;
        rearm = '0;
        if (out_valid && out_ready) begin
          g = int'(~out_idx_n);
          chk("t5_grant", 32'(out_idx_n), 32'(exp_q.pop_front()));
          ng++;
          if (g < N) begin
            rearm[g] = 1'b1;
            req_n[g] = 1'b1;
          end
          if (ng == 1) rearm = rearm | 9'h011;
        end
        tick();
      end
      chk("t5_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      req_n = '1;
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1; tick(); rst = 1'b0; tick();
    end
`endif

    // 6: reset mid-offer with three bits pending
    out_ready = 1'b0;
    req_n[1] = 1'b0; req_n[6] = 1'b0; req_n[7] = 1'b0;
    tick(); tick();
    chk("t6_valid_pre", 32'(out_valid), 32'd1);
    chk("t6_idx_pre",   32'(out_idx_n), 32'b1000);
    chk("t6_pend_pre",  32'(pend),      32'h0C2);
    rst = 1'b1; req_n = '1;
    tick();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_idx",   32'(out_idx_n), 32'hF);
    chk("t6_pend",  32'(pend),      32'd0);
    chk("t6_any",   32'(any_n),     32'd1);
    chk("t6_ovr",   32'(ovr_cnt),   32'd0);
    chk("t6_state", 32'(dbg_state_o), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    n_extra = 0;
    run_cycles(8, "t6");
    chk("t6_extra",   32'(n_extra),   32'd0);
    chk("t6_valid_q", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
